// File: rtl/recovery_ctrl.sv
// Pipeline recovery sequencer: flush on mispredict/mret, drain fetch and RAT restore, then one redirect pulse.
// Optional RECOVERY_PERF_EN adds perf_recoveries / perf_stall_cycles counters.
module recovery_ctrl #(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned ROB_PTR_W    = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 miss_valid,
  input  logic [PC_W-1:0]      miss_target,
  input  logic [ROB_PTR_W-1:0] miss_rob_ptr,
  input  logic                 mret_valid,
  input  logic [PC_W-1:0]      mepc,
  input  logic                 ifetch_busy,
  input  logic                 rat_restore_done,
  output logic                 flush_front,
  output logic                 flush_back,
  output logic                 stall_front,
  output logic                 rat_restore_req,
  output logic [ROB_PTR_W-1:0] rob_squash_ptr,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
`ifdef RECOVERY_PERF_EN
  output logic [31:0]          perf_recoveries,
  output logic [31:0]          perf_stall_cycles,
`endif
  output logic                 busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  state_e                 state_q;
  logic [PC_W-1:0]        target_q;
  logic [ROB_PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   restore_seen_q;
  logic                   flush_front_q;
  logic                   flush_back_q;
  logic                   stall_front_q;
  logic                   rat_req_q;
  logic                   redirect_valid_q;
  logic [PC_W-1:0]        redirect_pc_q;
  logic                   busy_q;
  logic                   drain_exit;

  // Leave DRAIN once the minimum drain time has elapsed, fetch is idle and the RAT is restored.
  assign drain_exit = (cnt_q == '0) && !ifetch_busy && (restore_seen_q || rat_restore_done);

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      target_q         <= '0;
      ptr_q            <= '0;
      cnt_q            <= '0;
      restore_seen_q   <= 1'b0;
      flush_front_q    <= 1'b0;
      flush_back_q     <= 1'b0;
      stall_front_q    <= 1'b0;
      rat_req_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mret_valid || miss_valid) begin
            state_q       <= FLUSH;
            target_q      <= mret_valid ? mepc : miss_target;
            ptr_q         <= mret_valid ? '0 : miss_rob_ptr;
            flush_front_q <= 1'b1;
            flush_back_q  <= 1'b1;
            stall_front_q <= 1'b1;
            rat_req_q     <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        FLUSH: begin
          state_q       <= DRAIN;
          cnt_q         <= CNT_W'(FLUSH_CYCLES - 1);
          flush_front_q <= 1'b0;
          flush_back_q  <= 1'b0;
          rat_req_q     <= 1'b0;
          if (rat_restore_done) restore_seen_q <= 1'b1;
        end
        DRAIN: begin
          if (rat_restore_done) restore_seen_q <= 1'b1;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          if (drain_exit) begin
            state_q          <= REDIRECT;
            stall_front_q    <= 1'b0;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= {target_q[PC_W-1:1], 1'b0};
          end
        end
        REDIRECT: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
          redirect_pc_q    <= '0;
          busy_q           <= 1'b0;
          restore_seen_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RECOVERY_PERF_EN
  logic [31:0] perf_rec_q;
  logic [31:0] perf_stall_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_rec_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == REDIRECT) perf_rec_q <= perf_rec_q + 32'd1;
      if (state_q == FLUSH || state_q == DRAIN) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_recoveries   = perf_rec_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

  assign flush_front     = flush_front_q;
  assign flush_back      = flush_back_q;
  assign stall_front     = stall_front_q;
  assign rat_restore_req = rat_req_q;
  assign rob_squash_ptr  = ptr_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_recovery_ctrl.sv
// Self-checking bench for recovery_ctrl: table-driven recovery scenarios with a redirect scoreboard.
// Perf counter checks compile in when RECOVERY_PERF_EN is defined.
module tb_recovery_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        miss_valid;
  logic [63:0] miss_target;
  logic [4:0]  miss_rob_ptr;
  logic        mret_valid;
  logic [63:0] mepc;
  logic        ifetch_busy;
  logic        rat_restore_done;
  logic        flush_front;
  logic        flush_back;
  logic        stall_front;
  logic        rat_restore_req;
  logic [4:0]  rob_squash_ptr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;
`ifdef RECOVERY_PERF_EN
  logic [31:0] perf_recoveries;
  logic [31:0] perf_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  recovery_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .miss_valid       (miss_valid),
    .miss_target      (miss_target),
    .miss_rob_ptr     (miss_rob_ptr),
    .mret_valid       (mret_valid),
    .mepc             (mepc),
    .ifetch_busy      (ifetch_busy),
    .rat_restore_done (rat_restore_done),
    .flush_front      (flush_front),
    .flush_back       (flush_back),
    .stall_front      (stall_front),
    .rat_restore_req  (rat_restore_req),
    .rob_squash_ptr   (rob_squash_ptr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
`ifdef RECOVERY_PERF_EN
    .perf_recoveries  (perf_recoveries),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic        mret;
    logic [63:0] target;
    logic [4:0]  ptr;
    logic [63:0] mepc;
    int          busy_until;  // ifetch_busy high for cycles k < busy_until
    int          restore_at;  // cycle k where rat_restore_done pulses
    int          extra_k;     // cycle k of a second (to-be-ignored) miss, 0 = none
    logic [63:0] exp_pc;
    logic [4:0]  exp_ptr;
    int          exp_k;       // cycle offset of the redirect pulse
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    int          k;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctrl_now();
    return {flush_front, flush_back, stall_front, rat_restore_req, redirect_valid, busy};
  endfunction

  task automatic idle_inputs();
    miss_valid       = 1'b0;
    miss_target      = '0;
    miss_rob_ptr     = '0;
    mret_valid       = 1'b0;
    mepc             = '0;
    ifetch_busy      = 1'b0;
    rat_restore_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t       e;
    logic [5:0] exp_ctrl;
    @(negedge clk);
    miss_valid       = v.miss;
    miss_target      = v.target;
    miss_rob_ptr     = v.ptr;
    mret_valid       = v.mret;
    mepc             = v.mepc;
    ifetch_busy      = 1'b0;
    rat_restore_done = 1'b0;
    sb.push_back('{pc: v.exp_pc, k: v.exp_k});
    for (int k = 1; k <= v.exp_k + 1; k++) begin
      @(negedge clk);
      miss_valid       = (k == v.extra_k);
      miss_target      = 64'hDEAD_0000;
      miss_rob_ptr     = 5'd3;
      mret_valid       = 1'b0;
      ifetch_busy      = (k < v.busy_until);
      rat_restore_done = (k == v.restore_at);
      if (k == 1)            exp_ctrl = 6'b111101;
      else if (k < v.exp_k)  exp_ctrl = 6'b001001;
      else if (k == v.exp_k) exp_ctrl = 6'b000011;
      else                   exp_ctrl = 6'b000000;
      chk($sformatf("v%0d_ctrl_k%0d", idx, k), 64'(ctrl_now()), 64'(exp_ctrl));
      if (k == 1) chk($sformatf("v%0d_squash_ptr", idx), 64'(rob_squash_ptr), 64'(v.exp_ptr));
      if (redirect_valid) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_spurious_redirect_k", idx), 64'(k), 64'(0));
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_redirect_pc", idx), redirect_pc, e.pc);
          chk($sformatf("v%0d_redirect_k", idx), 64'(k), 64'(e.k));
        end
      end
    end
    chk($sformatf("v%0d_redirects_pending", idx), 64'(sb.size()), 64'(0));
    sb.delete();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit no_redirect;
    // miss, mret, target, ptr, mepc, busy_until, restore_at, extra_k, exp_pc, exp_ptr, exp_k
    vecs.push_back('{1'b1, 1'b0, 64'h8000_1003, 5'd7,  64'h0,          0, 2, 0, 64'h8000_1002, 5'd7,  4});
    vecs.push_back('{1'b1, 1'b1, 64'h0000_1234, 5'd9,  64'h8000_0100, 0, 2, 0, 64'h8000_0100, 5'd0,  4});
    vecs.push_back('{1'b1, 1'b0, 64'h4000_0010, 5'd12, 64'h0,          9, 2, 0, 64'h4000_0010, 5'd12, 10});
    vecs.push_back('{1'b0, 1'b1, 64'h0,         5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd0, 4});
    vecs.push_back('{1'b1, 1'b0, 64'h0000_2001, 5'd1,  64'h0,          0, 6, 0, 64'h0000_2000, 5'd1,  7});
    vecs.push_back('{1'b1, 1'b0, 64'h0000_3000, 5'd2,  64'h0,          0, 3, 0, 64'h0000_3000, 5'd2,  4});
    vecs.push_back('{1'b1, 1'b0, 64'h0,         5'd31, 64'h0,          0, 2, 0, 64'h0,         5'd31, 4});
    vecs.push_back('{1'b1, 1'b0, 64'h8000_5555, 5'd4,  64'h0,          0, 2, 2, 64'h8000_5554, 5'd4,  4});
    vecs.push_back('{1'b1, 1'b0, 64'h8000_6000, 5'd5,  64'h0,          0, 2, 4, 64'h8000_6000, 5'd5,  4});

    idle_inputs();
    resetn = 1'b0;
    #3;
    chk("reset_ctrl", 64'(ctrl_now()), 64'(0));
    chk("reset_pc", redirect_pc, 64'h0);
    chk("reset_ptr", 64'(rob_squash_ptr), 64'(0));
`ifdef RECOVERY_PERF_EN
    chk("reset_perf", {perf_recoveries, perf_stall_cycles}, 64'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset in the middle of DRAIN: outputs clear at once and no redirect follows.
    @(negedge clk);
    miss_valid   = 1'b1;
    miss_target  = 64'h8000_7777;
    miss_rob_ptr = 5'd6;
    @(negedge clk);
    miss_valid = 1'b0;
    @(negedge clk);
    rat_restore_done = 1'b1;
    chk("pre_reset_busy", 64'(busy), 64'(1));
    resetn = 1'b0;
    #1;
    chk("midreset_ctrl", 64'(ctrl_now()), 64'(0));
    chk("midreset_ptr", 64'(rob_squash_ptr), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rat_restore_done = 1'b0;
    resetn = 1'b1;
    no_redirect = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (redirect_valid || busy) no_redirect = 1'b0;
    end
    chk("midreset_no_redirect", 64'(no_redirect), 64'(1));
`ifdef RECOVERY_PERF_EN
    chk("perf_after_reset", {perf_recoveries, perf_stall_cycles}, 64'h0);
`endif

    for (int i = 0; i < 3; i++) run_vec(vecs[0], 100 + i);
`ifdef RECOVERY_PERF_EN
    chk("perf_recoveries", 64'(perf_recoveries), 64'(3));
    chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(9));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
